// File: rtl/folded_majority_stream.sv
// Streaming majority voter: an N-vote frame arrives as W-bit beats, is popcounted
// across beats and compared against THRESH. Optional feature macro: MAJ_NEAR_FLAG_EN.
module folded_majority_stream #(
    parameter int N      = 57,
    parameter int W      = 8,
    parameter int THRESH = (N + 1) / 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W-1:0]               in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       y0,
    output logic [$clog2(N+1)-1:0]     out_count
`ifdef MAJ_NEAR_FLAG_EN
    ,
    output logic                       near
`endif
);

    localparam int B   = (N + W - 1) / W;
    localparam int CW  = $clog2(N + 1);
    localparam int LW  = N - (B - 1) * W;
    localparam int PW  = $clog2(W + 1);
    localparam int BIW = (B > 1) ? $clog2(B) : 1;

    localparam logic [W-1:0] FULL_MASK = {W{1'b1}};
    localparam logic [W-1:0] LAST_MASK = FULL_MASK >> (W - LW);

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [BIW-1:0]  beat_idx;
    logic [CW-1:0]   acc;
    logic            accept;
    logic            last_beat;
    logic [PW-1:0]   beat_pop;
    logic [CW-1:0]   total;

    function automatic logic [PW-1:0] popcount(input logic [W-1:0] v);
        logic [PW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < W; i++) begin
            cnt = cnt + PW'(v[i]);
        end
        return cnt;
    endfunction

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;
    assign last_beat = (beat_idx == BIW'(B - 1));

    // Padding bits above LW in the final beat never reach the count.
    assign beat_pop  = popcount(in_data & (last_beat ? LAST_MASK : FULL_MASK));
    assign total     = acc + CW'(beat_pop);

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_next = state;
        case (state)
            ACCUM:   if (accept && last_beat) state_next = HOLD;
            HOLD:    if (out_ready)           state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // NOTE: state is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_idx  <= '0;
            acc       <= '0;
            y0        <= 1'b0;
            out_count <= '0;
`ifdef MAJ_NEAR_FLAG_EN
            near      <= 1'b0;
`endif
        end else if (accept) begin
            if (last_beat) begin
                out_count <= total;
                y0        <= (total >= CW'(THRESH));
`ifdef MAJ_NEAR_FLAG_EN
                near      <= (total == CW'(THRESH)) || (total == CW'(THRESH - 1));
`endif
                acc       <= '0;
                beat_idx  <= '0;
            end else begin
                acc       <= total;
                beat_idx  <= beat_idx + BIW'(1);
            end
        end
    end

endmodule

// File: doc/folded_majority_stream.md
Name: folded_majority_stream

Overview:
- Sequential, parametrised successor to the flat combinational majority voter.
- Accepts an N-input vote vector folded into W-bit beats over a valid/ready stream and accumulates the popcount across beats.
- Emits y0 = (count >= THRESH) plus the raw count through a valid/ready result port.
- Used where wide majority (N=57 and up) is too large to flatten in one cycle; sits between the vote-collection fabric and the decision consumer.

Parameters:
- N, 57, number of votes per frame; N >= 1.
- W, 8, votes per beat; 1 <= W <= N.
- THRESH, (N+1)/2, minimum ones for y0=1; 1 <= THRESH <= N.
- Derived, not overridable: B = ceil(N/W) beats per frame; CW = clog2(N+1) count width; LW = N - (B-1)*W valid bits in the final beat.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  beat offered.
- in_ready  out  1  block accepts a beat.
- in_data  in  W  vote bits; bit i is vote (beat_idx*W + i).
- out_valid  out  1  frame result available.
- out_ready  in  1  consumer accepts the result.
- y0  out  1  majority decision, (count >= THRESH).
- out_count  out  CW  total ones in the frame, 0..N.

Behaviour:
- States: ACCUM and HOLD.
- Reset (rst=1 at an edge): state=ACCUM, beat_idx=0, acc=0, out_valid=0, y0=0, out_count=0. rst has priority over every other event, including mid-frame and in HOLD; any partial frame is discarded.
- in_ready = (state==ACCUM). It is combinational from state only, never from in_valid.
- A beat is accepted when in_valid && in_ready. Cycles with in_valid=0 are bubbles: no state change, result unaffected.
- Non-final beat (beat_idx < B-1): acc += popcount(in_data); beat_idx++.
- Final beat (beat_idx == B-1):
  - Only bits [LW-1:0] are counted; bits [W-1:LW] are ignored, whatever their value.
  - Next cycle: out_count = acc + popcount(masked), y0 = (out_count >= THRESH), out_valid=1, state=HOLD, acc=0, beat_idx=0.
- Latency: out_valid rises exactly 1 cycle after the final beat is accepted.
- Arithmetic: acc and out_count are CW bits wide; overflow is impossible by construction. Per-beat popcount uses clog2(W+1) bits, zero-extended.
- HOLD:
  - in_ready=0.
  - y0, out_count and out_valid are held stable while out_ready=0, for any number of cycles.
  - On out_valid && out_ready: out_valid=0 and state=ACCUM on the next edge, so in_ready=1 the following cycle.
  - A beat cannot be accepted in the same cycle as the result handshake.
- After the handshake, y0 and out_count keep their last values; they are don't-care while out_valid=0.
- Degenerate case B=1 (W=N): each accepted beat is a complete frame.
- No X propagation: in_data is ignored when the beat is not accepted.

Optional Feature:
- Macro: MAJ_NEAR_FLAG_EN.
- Defined: adds output port near (out, 1 bit), registered with the result. near = (out_count == THRESH) || (out_count == THRESH-1), i.e. the decision hinges on a single vote. Reset value 0; held in HOLD exactly like y0.
- Undefined: the port does not exist, and there is no extra logic or latency. All other behaviour is identical in both builds.

Test Plan:
- Reset: assert rst 2 cycles mid-stream, then deassert -> in_ready=1, out_valid=0, y0=0, out_count=0.
- N=57,W=8 (B=8, LW=1), 8 beats of 0xFF back-to-back -> out_valid 1 cycle after beat 8, out_count=57, y0=1. Masked bits 7:1 of the final beat are not counted.
- Threshold edge: beats FF,FF,FF,0F,00,00,00 then final 01 -> out_count=29, y0=1. Same frame with final FE -> out_count=28, y0=0. With MAJ_NEAR_FLAG_EN, near=1 in both cases.
- Backpressure: complete a frame, hold out_ready=0 for 5 cycles -> out_valid=1, y0/out_count stable, in_ready=0 throughout. Raise out_ready -> out_valid=0 and in_ready=1 on the next cycle.
- Reset mid-frame: accept 3 beats of FF, pulse rst, then send an all-zero frame -> out_count=0, y0=0; no residue from the first 3 beats.
- Bubbles: all-ones frame with in_valid low for 2 cycles between each beat -> out_count=57, y0=1; out_valid 1 cycle after the final accepted beat.
